// File: rtl/pc_predict.sv
// pc_predict: next-PC generator with a saturating-counter branch predictor table.
// Optional gshare indexing is enabled by defining PC_PREDICT_GSHARE_EN.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   ena                 advance enable (low = fetch stall)
//   in_last_valid/pc/inst  fetched instruction
//   out_next_pc         registered next fetch address
//   out_pred_taken      registered prediction of the last predicted branch
//   out_pred_index      registered table index of the last predicted branch
//   in_upd_valid/index/taken  resolved branch counter update
//   in_misbranch, in_correct_address  redirect on mispredict
//   out_clear_all       combinational pipeline flush
module pc_predict #(
    parameter int XLEN = 32,
    parameter int IDX_BITS = 6,
    parameter int CNT_BITS = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                in_last_valid,
    input  logic [XLEN-1:0]     in_last_pc,
    input  logic [31:0]         in_last_inst,
    output logic [XLEN-1:0]     out_next_pc,
    output logic                out_pred_taken,
    output logic [IDX_BITS-1:0] out_pred_index,
    input  logic                in_upd_valid,
    input  logic [IDX_BITS-1:0] in_upd_index,
    input  logic                in_upd_taken,
    input  logic                in_misbranch,
    input  logic [XLEN-1:0]     in_correct_address,
    output logic                out_clear_all
);
    localparam int DEPTH = 1 << IDX_BITS;
    localparam int CNT_INIT_I = (1 << (CNT_BITS - 1)) - 1;
    localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'(CNT_INIT_I);
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    logic [CNT_BITS-1:0] cnt [DEPTH];
    logic [IDX_BITS-1:0] idx;
    logic                pred;
    logic                adv, is_br, is_jal;
    logic [XLEN-1:0]     b_imm, j_imm, next_pc;
    logic                next_taken;
    logic [IDX_BITS-1:0] next_index;
    logic [CNT_BITS-1:0] upd_cur;

`ifdef PC_PREDICT_GSHARE_EN
    logic [IDX_BITS-1:0] ghr;
    assign idx = in_last_pc[IDX_BITS+1:2] ^ ghr;
    always_ff @(posedge clk) begin
        if (rst)
            ghr <= '0;
        else if (in_upd_valid)
            ghr <= {ghr[IDX_BITS-2:0], in_upd_taken};
    end
`else
    assign idx = in_last_pc[IDX_BITS+1:2];
`endif

    assign out_clear_all = in_misbranch;
    // Table read is combinational, so a same-cycle update is not visible yet.
    assign pred = cnt[idx][CNT_BITS-1];
    assign upd_cur = cnt[in_upd_index];

    assign b_imm = {{(XLEN-12){in_last_inst[31]}}, in_last_inst[7], in_last_inst[30:25],
                    in_last_inst[11:8], 1'b0};
    assign j_imm = {{(XLEN-20){in_last_inst[31]}}, in_last_inst[19:12], in_last_inst[20],
                    in_last_inst[30:21], 1'b0};

    always_comb begin
        adv = ena && in_last_valid;
        is_br = adv && in_last_inst[6:0] == 7'b1100011;
        is_jal = adv && in_last_inst[6:0] == 7'b1101111;
        next_pc = in_misbranch ? in_correct_address :
                  !adv ? out_next_pc :
                  (is_br && pred) ? in_last_pc + b_imm :
                  is_jal ? in_last_pc + j_imm :
                  in_last_pc + XLEN'(4);
        next_taken = in_misbranch ? 1'b0 : is_br ? pred : adv ? 1'b0 : out_pred_taken;
        next_index = (!in_misbranch && is_br) ? idx : out_pred_index;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_next_pc <= RESET_PC;
            out_pred_taken <= 1'b0;
            out_pred_index <= '0;
        end else begin
            out_next_pc <= next_pc;
            out_pred_taken <= next_taken;
            out_pred_index <= next_index;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                cnt[i] <= CNT_INIT;
        end else if (in_upd_valid) begin
            cnt[in_upd_index] <= in_upd_taken ? (upd_cur == CNT_MAX ? upd_cur : upd_cur + 1'b1)
                                              : (upd_cur == '0 ? upd_cur : upd_cur - 1'b1);
        end
    end
endmodule

// File: tb/tb_pc_predict.sv
// tb_pc_predict: directed self-checking bench for pc_predict.
module tb_pc_predict;
    localparam logic [31:0] ADDI   = 32'h0000_0013;
    localparam logic [31:0] BEQ40  = 32'h0400_0063;
    localparam logic [31:0] JAL_M8 = 32'hFF9F_F06F;
    localparam logic [31:0] JAL_P8 = 32'h0080_006F;
    localparam logic [31:0] JALR   = 32'h0000_8067;

    logic        clk = 1'b0;
    logic        rst, ena, in_last_valid, in_upd_valid, in_upd_taken, in_misbranch;
    logic [31:0] in_last_pc, in_last_inst, in_correct_address, out_next_pc;
    logic [5:0]  in_upd_index, out_pred_index;
    logic        out_pred_taken, out_clear_all;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_predict dut (
        .clk(clk), .rst(rst), .ena(ena), .in_last_valid(in_last_valid),
        .in_last_pc(in_last_pc), .in_last_inst(in_last_inst),
        .out_next_pc(out_next_pc), .out_pred_taken(out_pred_taken),
        .out_pred_index(out_pred_index), .in_upd_valid(in_upd_valid),
        .in_upd_index(in_upd_index), .in_upd_taken(in_upd_taken),
        .in_misbranch(in_misbranch), .in_correct_address(in_correct_address),
        .out_clear_all(out_clear_all)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] inst);
        ena = 1'b1;
        in_last_valid = 1'b1;
        in_last_pc = pc;
        in_last_inst = inst;
    endtask

    task automatic upd(input logic [5:0] idx, input logic taken);
        in_upd_valid = 1'b1;
        in_upd_index = idx;
        in_upd_taken = taken;
    endtask

    initial begin
        rst = 1'b1;
        fetch(32'h200, BEQ40);
        upd(6'd0, 1'b1);
        in_misbranch = 1'b1;
        in_correct_address = 32'h3000;
        #1 chk("clear_in_rst", out_clear_all, 1);
        tick();
        chk("rst_pc", out_next_pc, 0);
        chk("rst_taken", out_pred_taken, 0);
        chk("rst_index", out_pred_index, 0);
        rst = 1'b0;
        in_misbranch = 1'b0;
        in_upd_valid = 1'b0;
        fetch(32'h100, ADDI);
        tick();
        chk("addi_pc", out_next_pc, 32'h104);
        chk("addi_taken", out_pred_taken, 0);
        fetch(32'h2C, BEQ40);
        tick();
        chk("beq2c_pc", out_next_pc, 32'h30);
        chk("beq2c_index", out_pred_index, 11);
        fetch(32'h200, BEQ40);
        tick();
        chk("beq_fresh_pc", out_next_pc, 32'h204);
        chk("beq_fresh_index", out_pred_index, 0);
        upd(6'd0, 1'b1);
        tick();
        chk("beq_same_cycle_upd", out_next_pc, 32'h204);
        ena = 1'b0;
        tick();
        chk("stall_hold1", out_next_pc, 32'h204);
        tick();
        chk("stall_hold2", out_next_pc, 32'h204);
        in_upd_valid = 1'b0;
        fetch(32'h200, BEQ40);
        tick();
        chk("beq_taken_pc", out_next_pc, 32'h240);
        chk("beq_taken", out_pred_taken, 1);
        fetch(32'h1000, JAL_M8);
        tick();
        chk("jal_back_pc", out_next_pc, 32'hFF8);
        chk("jal_clears_taken", out_pred_taken, 0);
        fetch(32'hFFFF_FFFC, JAL_P8);
        tick();
        chk("jal_wrap_pc", out_next_pc, 32'h4);
        fetch(32'h500, JALR);
        tick();
        chk("jalr_pc", out_next_pc, 32'h504);
        chk("jalr_holds_index", out_pred_index, 0);
        ena = 1'b0;
        upd(6'd0, 1'b0);
        tick();
        in_upd_valid = 1'b0;
        fetch(32'h200, BEQ40);
        tick();
        chk("sat_high_pc", out_next_pc, 32'h240);
        ena = 1'b0;
        upd(6'd0, 1'b0);
        tick();
        in_upd_valid = 1'b0;
        fetch(32'h200, BEQ40);
        tick();
        chk("dec_to_weak_nt_pc", out_next_pc, 32'h204);
        ena = 1'b0;
        upd(6'd11, 1'b0);
        tick();
        tick();
        upd(6'd11, 1'b1);
        tick();
        in_upd_valid = 1'b0;
        fetch(32'h2C, BEQ40);
        tick();
        chk("sat_low_pc", out_next_pc, 32'h30);
        chk("sat_low_taken", out_pred_taken, 0);
        chk("sat_low_index", out_pred_index, 11);
        ena = 1'b0;
        in_misbranch = 1'b1;
        in_correct_address = 32'h3000;
        #1 chk("clear_comb", out_clear_all, 1);
        tick();
        chk("misbranch_pc", out_next_pc, 32'h3000);
        in_misbranch = 1'b0;
        #1 chk("clear_low", out_clear_all, 0);
        tick();
        chk("stall_hold_pc", out_next_pc, 32'h3000);
        upd(6'd0, 1'b1);
        tick();
        tick();
        rst = 1'b1;
        in_misbranch = 1'b1;
        fetch(32'h200, BEQ40);
        tick();
        chk("rst2_pc", out_next_pc, 0);
        chk("rst2_taken", out_pred_taken, 0);
        rst = 1'b0;
        in_misbranch = 1'b0;
        in_upd_valid = 1'b0;
        tick();
        chk("table_reset_pc", out_next_pc, 32'h204);
        ena = 1'b0;
        upd(6'd5, 1'b1);
        tick();
        tick();
        in_upd_valid = 1'b0;
        fetch(32'h200, BEQ40);
        tick();
`ifdef PC_PREDICT_GSHARE_EN
        chk("history_index", out_pred_index, 6'b000011);
`else
        chk("history_index", out_pred_index, 6'b000000);
`endif
        chk("history_pc", out_next_pc, 32'h204);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_predict.md
PC_PREDICT -- requirements
Module: pc_predict

Interface
Parameters (name, default, meaning):
REQ-001 XLEN, 32, address/data width in bits.
REQ-002 IDX_BITS, 6, prediction table index width; table depth is 2^IDX_BITS entries.
REQ-003 CNT_BITS, 2, saturating counter width per entry; legal range 1..4.
REQ-004 RESET_PC, 0, value of out_next_pc after reset.

Ports (name, direction, width, meaning):
REQ-005 clk  in  1  clock.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 ena  in  1  advance enable; low = fetch stall.
REQ-008 in_last_valid  in  1  in_last_pc/in_last_inst hold a fetched instruction.
REQ-009 in_last_pc  in  XLEN  PC of fetched instruction.
REQ-010 in_last_inst  in  32  fetched instruction word.
REQ-011 out_next_pc  out  XLEN  registered next fetch address.
REQ-012 out_pred_taken  out  1  registered prediction for the branch just predicted.
REQ-013 out_pred_index  out  IDX_BITS  registered table index used; travels with the branch down the pipeline.
REQ-014 in_upd_valid  in  1  a branch resolved this cycle.
REQ-015 in_upd_index  in  IDX_BITS  index returned with the resolved branch.
REQ-016 in_upd_taken  in  1  actual branch outcome.
REQ-017 in_misbranch  in  1  resolved branch was mispredicted.
REQ-018 in_correct_address  in  XLEN  redirect target.
REQ-019 out_clear_all  out  1  pipeline flush, combinational.

Function
REQ-020 out_clear_all SHALL equal in_misbranch in the same cycle.
REQ-021 Table index SHALL be in_last_pc[IDX_BITS+1:2], XORed per REQ-043 when enabled.
REQ-022 Prediction taken SHALL be the MSB of the indexed counter.
REQ-023 Next-PC priority, registered on the clock edge: (1) in_misbranch -> in_correct_address, independent of ena; (2) ena && in_last_valid && opcode 1100011 -> in_last_pc+B_IMM if predicted taken, else in_last_pc+4; (3) ena && in_last_valid && opcode 1101111 -> in_last_pc+J_IMM; (4) ena && in_last_valid, any other opcode (including JALR) -> in_last_pc+4; (5) otherwise hold.
REQ-024 B_IMM and J_IMM SHALL be the RV32I sign-extended B-type and J-type immediates; all additions SHALL be modulo 2^XLEN (wrap, no flag).
REQ-025 out_pred_taken/out_pred_index SHALL update only in case (2); cases (1),(3),(4) SHALL clear out_pred_taken; case (5) SHALL hold both.
REQ-026 Latency: out_next_pc SHALL reflect the inputs one cycle after sampling.
REQ-027 When in_upd_valid, counter[in_upd_index] SHALL increment if in_upd_taken, else decrement, saturating at 2^CNT_BITS-1 and 0.
REQ-028 Counter updates SHALL occur regardless of ena and in_misbranch.
REQ-029 Same-cycle prediction read and update of one entry: the prediction SHALL use the pre-update value.
REQ-030 The counter table SHALL never be cleared by in_misbranch.

Reset
REQ-031 On rst: out_next_pc=RESET_PC, out_pred_taken=0, out_pred_index=0.
REQ-032 On rst: every counter = 2^(CNT_BITS-1)-1 (weakly not-taken); ghr=0.
REQ-033 rst SHALL override in_misbranch, in_upd_valid and ena in the same cycle.
REQ-034 out_clear_all SHALL still follow in_misbranch during rst.

Configuration
REQ-040 Macro PC_PREDICT_GSHARE_EN selects gshare indexing.
REQ-041 Without the macro: index per REQ-021 with no history; no ghr register exists.
REQ-042 With the macro: an IDX_BITS-wide global history register ghr, on in_upd_valid (non-reset) shifted as {ghr[IDX_BITS-2:0], in_upd_taken}.
REQ-043 With the macro: prediction index = in_last_pc[IDX_BITS+1:2] XOR ghr (pre-shift value); update still uses in_upd_index unmodified.

Verification
REQ-050 Reset, then ena=1, in_last_valid=1, pc=0x100, inst=ADDI -> out_next_pc=0x104, out_pred_taken=0.
REQ-051 BEQ at 0x200, offset +0x40, fresh table -> 0x204; three in_upd_valid taken updates to its index, repeat -> 0x240, out_pred_taken=1; a fourth taken update leaves the counter at 3.
REQ-052 JAL at 0x1000, offset -8 -> 0xFF8; JAL at 0xFFFFFFFC, offset +8 -> 0x00000004 (wrap).
REQ-053 ena=0, in_misbranch=1, in_correct_address=0x3000 -> out_clear_all=1 same cycle, out_next_pc=0x3000 next cycle; with ena=0 and no misbranch, out_next_pc holds.
REQ-054 rst asserted with in_misbranch=1 and in_upd_valid=1 -> out_next_pc=RESET_PC, all counters at reset value.
REQ-055 With PC_PREDICT_GSHARE_EN: two taken updates, then BEQ at pc whose [7:2]=0 -> out_pred_index=6'b000011; without the macro -> 0.
